// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - instruction memory, redirect and decoder signals of the fetch stage
interface fetch_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 20
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_req;
  logic [15:0]           imem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  stall;
  logic [31:0]           instr_out;
  logic                  instr_is32;
  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output imem_addr, imem_req, instr_out, instr_is32, instr_valid, instr_pc,
    input  imem_data, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_addr, imem_req, instr_out, instr_is32, instr_valid, instr_pc,
    output imem_data, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - halfword prefetch queue assembling 16/32-bit instructions for the decoder
module fetch_prefetch_queue #(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

  logic [15:0]           data_q   [DEPTH];
  logic [15:0]           data_d   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_tag_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_tag_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

  logic [PW-1:0] head_ptr1;
  logic [15:0]   head_hw;
  logic [15:0]   next_hw;
  logic          head_is32;
  logic          out_valid;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          pop;
  logic [CW-1:0] pop_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Presentation depends only on registered queue state.
  always_comb begin
    head_ptr1 = ptr_inc(head_q);
    head_hw   = data_q[head_q];
    next_hw   = data_q[head_ptr1];
    head_is32 = head_hw[15];
    out_valid = head_is32 ? (count_q >= CW'(2)) : (count_q != '0);

    bus.instr_valid = out_valid;
    bus.instr_is32  = out_valid & head_is32;
    bus.instr_pc    = out_valid ? pc_tag_q[head_q] : '0;
    if (!out_valid) begin
      bus.instr_out = 32'h0;
    end else if (head_is32) begin
      bus.instr_out = {next_hw, head_hw};
    end else begin
      bus.instr_out = {16'h0, head_hw};
    end
  end

  // Counting the in-flight read as occupied guarantees its response always has a slot.
  always_comb begin
    occupancy    = {1'b0, count_q} + (CW + 1)'(inflight_q);
    issue        = !reset && !bus.redirect_valid && (occupancy < DEPTH_OCC);
    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc_q;
  end

  always_comb begin
    data_d          = data_q;
    pc_tag_d        = pc_tag_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = inflight_q;
    inflight_addr_d = inflight_addr_q;
    pop             = out_valid && !bus.stall;
    pop_cnt         = '0;

    if (bus.redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
    end else begin
      if (inflight_q) begin
        data_d[tail_q]   = bus.imem_data;
        pc_tag_d[tail_q] = inflight_addr_q;
        tail_d           = ptr_inc(tail_q);
      end
      if (pop) begin
        pop_cnt = head_is32 ? CW'(2) : CW'(1);
        head_d  = head_is32 ? ptr_inc(head_ptr1) : head_ptr1;
      end
      count_d    = count_q + CW'(inflight_q) - pop_cnt;
      inflight_d = issue;
      if (issue) begin
        inflight_addr_d = fetch_pc_q;
        fetch_pc_d      = fetch_pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clock) begin
    data_q   <= data_d;
    pc_tag_q <= pc_tag_d;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Front-end fetch stage sitting between the instruction memory and the 32-bit decoder.
- Streams 16-bit halfwords from instruction memory into a small queue, tagging each with its address.
- Assembles 16-bit or 32-bit instructions and presents them to the decoder with their PC.
- Supports stall from downstream and branch redirect/flush from the execute stage.

Parameters:
- ADDR_WIDTH, 20, instruction memory halfword address width.
- DEPTH, 4, queue capacity in halfwords; must be >= 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_WIDTH  halfword address presented to instruction memory.
- imem_req  output  1  read request. Data returns exactly one cycle later.
- imem_data  input  16  read data for the request issued in the previous cycle.
- redirect_valid  input  1  taken branch/jump from execute; flush and refetch.
- redirect_pc  input  ADDR_WIDTH  new fetch address, sampled when redirect_valid=1.
- stall  input  1  decoder/execute not accepting; hold current instruction.
- instr_out  output  32  [15:0]=first halfword; [31:16]=second halfword for 32-bit instructions, 0 for 16-bit.
- instr_is32  output  1  head instruction is 32-bit (first halfword bit 15 = 1).
- instr_valid  output  1  instr_out/instr_pc valid this cycle.
- instr_pc  output  ADDR_WIDTH  address of the first halfword of the presented instruction.

Behaviour:
- Reset (reset=1 at a clock edge):
  - fetch_pc=RESET_PC; queue empty; in-flight flag cleared.
  - imem_req=0; instr_valid=0; instr_out=0; instr_is32=0; instr_pc=0.
- Queue: circular buffer of DEPTH entries {halfword, address}; head/tail pointers wrap modulo DEPTH; count held 0..DEPTH.
- Request issue: imem_req=1 with imem_addr=fetch_pc when (count + inflight) < DEPTH and reset=0 and redirect_valid=0. On issue, fetch_pc increments by 1 and wraps from 2^ADDR_WIDTH-1 to 0.
- Response: the cycle after an issued request, imem_data is written to the tail with the address of that request. Response is dropped if a redirect occurred in the issue cycle or the response cycle.
- Output (function of registered state only):
  - Head bit15=0: valid when count>=1; instr_out={16'h0, head}.
  - Head bit15=1: valid when count>=2; instr_out={head+1, head}.
  - When invalid, instr_out, instr_is32 and instr_pc drive 0.
- Consume: instr_valid=1 and stall=0 pops 1 or 2 entries at the clock edge.
- Push and pop in the same cycle are legal; count updates by push minus pop.
- Stall: outputs held stable and queue keeps filling until full. Full means no new request and no overflow ever.
- Redirect priority: redirect_valid > pop/push > stall.
  - On redirect: queue emptied, in-flight response dropped, fetch_pc=redirect_pc.
  - instr_valid=0 the cycle after the redirect.
  - First request to redirect_pc is issued the cycle after the redirect. instr_valid reaches the decoder 2 cycles after that request for 16-bit, 3 for 32-bit.
- A 32-bit instruction whose halfwords straddle the address wrap is legal: second halfword comes from address 0. instr_pc is the first halfword's address.
- Startup latency: reset released at cycle 0 → request to RESET_PC at cycle 0 → entry written at end of cycle 1 → instr_valid in cycle 2 (16-bit) or cycle 3 (32-bit).
- Reset asserted mid-operation discards everything, including in-flight data, identically to power-up reset.

Test Plan:
1. Memory [0]=16'h0123, [1]=16'h0456, stall=0 → instr_valid cycle 2 with instr_out=32'h00000123, pc=0; cycle 3 instr_out=32'h00000456, pc=1; imem_addr increments 0,1,2,3.
2. Memory [0]=16'h8001, [1]=16'h1234 → first valid in cycle 3, instr_out=32'h12348001, instr_is32=1, pc=0. Next instruction has pc=2.
3. stall held for 8 cycles with DEPTH=4 → imem_req stops once count+inflight=4; instr_out stays constant. After release, instructions pop in order with no loss or duplication.
4. redirect_valid=1, redirect_pc=20'h00100 with queue full and a request in flight → next cycle instr_valid=0 and count=0; stale response not enqueued; first valid instr_pc=20'h00100.
5. redirect_pc=20'hFFFFF with [FFFFF]=16'h8ABC, [00000]=16'h0011 → instr_out=32'h00118ABC, instr_pc=20'hFFFFF; next imem_addr continues at 20'h00001 or later.
6. reset asserted 1 cycle while instr_valid=1 → next cycle all outputs 0. Fetch restarts at RESET_PC with startup latency as in scenario 1.
